instruction_fetch_unit: RTL

Decoupled front end that drives the core's instruction stream. It issues pipelined 64-bit-address read requests to a variable-latency instruction memory and buffers the returned 32-bit words with their PCs in a small FIFO. It presents them to the decode/execute core over a valid/ready interface. Control-flow redirects (taken branch, JAL/JALR) flush the buffer and discard stale in-flight responses.

---
 rtl/instruction_fetch_unit_if.sv | 34 +++
 rtl/instruction_fetch_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit (master) and its environment: the
// instruction memory, the decode/execute core and the redirect source (slave).
interface instruction_fetch_unit_if;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_address;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_address,
        output inst_valid, inst_data, inst_pc,
        output fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_address,
        input  inst_valid, inst_data, inst_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Decoupled instruction fetch front end: pipelined requests to a
// variable-latency instruction memory, an in-order response FIFO of
// {pc, instr}, and redirect handling that flushes the FIFO and drops the
// responses of every request accepted at or before the redirect edge.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect raises a
// sticky fetch_fault and halts request issue). Without it, fetch_fault is 0
// and redirect_pc[1:0] is forced to 00.
// All bus outputs are registered from the next-state values, so they are
// pure functions of state and hold their reset values while reset is low.
module instruction_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                            clock,
    input  logic                            reset,
    instruction_fetch_unit_if.master        bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fifo_entry_t;

    fifo_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
    logic [CNT_W-1:0]  count, count_next, count_after_pop;
    logic [CNT_W-1:0]  inflight, inflight_next;
    logic [CNT_W-1:0]  drop, drop_next;
    logic [SUM_W-1:0]  credit;
    logic [63:0]       fetch_pc, fetch_pc_next;
    logic [63:0]       resp_pc, resp_pc_next;
    logic [63:0]       redirect_target;
    logic              redirect_bad;
    logic              fault_next;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic              req_valid_next;
    fifo_entry_t       head_next;

    // Effective redirect target and alignment fault condition
`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = bus.redirect_pc;
    assign redirect_bad    = (bus.redirect_pc[1:0] != 2'b00);
`else
    assign redirect_target = {bus.redirect_pc[63:2], 2'b00};
    assign redirect_bad    = 1'b0;
`endif

    // Next-state computation for counters, pointers, PCs and registered outputs
    always_comb begin
        req_fire        = bus.imem_req_valid && bus.imem_req_ready;
        pop             = bus.inst_valid && bus.inst_ready;
        push            = bus.imem_resp_valid && (drop == '0);
        fetch_pc_next   = fetch_pc;
        resp_pc_next    = resp_pc;
        rd_ptr_next     = rd_ptr;
        wr_ptr_next     = wr_ptr;
        count_next      = count;
        drop_next       = drop;
        fault_next      = bus.fetch_fault;
        count_after_pop = count - CNT_W'(pop);
        inflight_next   = inflight + CNT_W'(req_fire) - CNT_W'(bus.imem_resp_valid);

        if (req_fire) begin
            fetch_pc_next = fetch_pc + 64'd4;
        end

        if (bus.redirect_valid) begin
            // Everything still outstanding after this edge belongs to the old stream
            fetch_pc_next = redirect_target;
            resp_pc_next  = redirect_target;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
            drop_next     = inflight_next;
            fault_next    = redirect_bad;
        end else begin
            if (bus.imem_resp_valid) begin
                if (drop != '0) begin
                    drop_next = drop - CNT_W'(1);
                end else begin
                    resp_pc_next = resp_pc + 64'd4;
                    wr_ptr_next  = wr_ptr + PTR_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + PTR_W'(1);
            end
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end

        // Head after this edge: zero when empty, bypass the pushed word when it lands alone
        if (bus.redirect_valid || count_next == '0) begin
            head_next = '0;
        end else if (count_after_pop == '0) begin
            head_next = '{pc: resp_pc, instr: bus.imem_resp_data};
        end else begin
            head_next = mem[rd_ptr_next];
        end

        // Issue only while buffer space covers every live (non-dropped) request
        credit         = SUM_W'(count_next) + SUM_W'(inflight_next) - SUM_W'(drop_next);
        req_valid_next = !fault_next
                         && (inflight_next < CNT_W'(DEPTH))
                         && (credit < SUM_W'(DEPTH));
    end

    // Control state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc             <= RESET_PC;
            resp_pc              <= RESET_PC;
            rd_ptr               <= '0;
            wr_ptr               <= '0;
            count                <= '0;
            inflight             <= '0;
            drop                 <= '0;
            bus.fetch_fault      <= 1'b0;
            bus.imem_req_valid   <= 1'b0;
            bus.imem_req_address <= RESET_PC;
            bus.inst_valid       <= 1'b0;
            bus.inst_data        <= '0;
            bus.inst_pc          <= '0;
        end else begin
            fetch_pc             <= fetch_pc_next;
            resp_pc              <= resp_pc_next;
            rd_ptr               <= rd_ptr_next;
            wr_ptr               <= wr_ptr_next;
            count                <= count_next;
            inflight             <= inflight_next;
            drop                 <= drop_next;
            bus.fetch_fault      <= fault_next;
            bus.imem_req_valid   <= req_valid_next;
            bus.imem_req_address <= fetch_pc_next;
            bus.inst_valid       <= (count_next != '0);
            bus.inst_data        <= head_next.instr;
            bus.inst_pc          <= head_next.pc;
        end
    end

    // FIFO storage; contents are only read behind a valid count
    always_ff @(posedge clock) begin
        if (push && !bus.redirect_valid) begin
            mem[wr_ptr] <= '{pc: resp_pc, instr: bus.imem_resp_data};
        end
    end
endmodule
